seq_multiplier_n: RTL and testbench

- Iterative shift-add multiplier, parametrised in operand width N.
- Supports an unsigned mode and a two's-complement signed mode.
- Uses a Start/Busy/Done handshake and retires one multiplier bit per clock.
- Successor to the combinational 4-bit array multiplier. Drives the same DE10-LITE HEX display path: product nibbles go to the segment decoders.

---
 rtl/seq_multiplier_n_pkg.sv | 21 ++
 rtl/seq_multiplier_n_if.sv | 25 ++
 rtl/seq_multiplier_n_datapath.sv | 48 ++++
 rtl/seq_multiplier_n.sv | 86 ++++++++
 tb/tb_seq_multiplier_n.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_n_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_multiplier_n_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Legal operand widths.
    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    // Bit-counter width: must be able to hold the value N itself.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_n_if.sv
// Start/Busy/Done handshake bundle for seq_multiplier_n.
// Signal names are from the multiplier's point of view.
interface seq_multiplier_n_if #(
    parameter int N = 4
) ();
    logic             i_start;
    logic             i_signed_mode;
    logic [N-1:0]     i_a;
    logic [N-1:0]     i_b;
    logic             o_busy;
    logic             o_done;
    logic [2*N-1:0]   o_p;

    // Requester side: drives operands, observes status and product.
    modport master (
        output i_start, i_signed_mode, i_a, i_b,
        input  o_busy, o_done, o_p
    );

    // Multiplier side.
    modport slave (
        input  i_start, i_signed_mode, i_a, i_b,
        output o_busy, o_done, o_p
    );
endinterface

// File: rtl/seq_multiplier_n_datapath.sv
// Shift-add datapath: {carry, high, low} accumulator, N+1-bit adder,
// one multiplier bit retired per step, optional negation into P.
module shift_add_datapath #(
    parameter int N = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,    // start of a multiply
    input  logic             i_step,    // one add/shift iteration
    input  logic             i_fix,     // write result into P
    input  logic             i_neg,     // result sign flag
    input  logic [N-1:0]     i_mcand,   // latched multiplicand magnitude
    input  logic [N-1:0]     i_mplier,  // multiplier magnitude at load
    output logic [2*N-1:0]   o_p
);

    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_p;
    logic [N-1:0]   w_hi;
    logic [N:0]     w_addend;
    logic [N:0]     w_sum;

    assign w_hi     = r_acc[2*N-1:N];
    assign w_addend = r_acc[0] ? {1'b0, i_mcand} : '0;
    // Carry is kept so the right shift brings it into the top bit.
    assign w_sum    = {1'b0, w_hi} + w_addend;

    // Accumulator: load multiplier into low half, then add-and-shift.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_acc <= '0;
        else if (i_load)
            r_acc <= {{N{1'b0}}, i_mplier};
        else if (i_step)
            r_acc <= {w_sum, r_acc[N-1:1]};
    end

    // Product register: only written at the fix-up step (or cleared by reset).
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_p <= '0;
        else if (i_fix)
            r_p <= i_neg ? -r_acc : r_acc;
    end

    assign o_p = r_p;

endmodule

// File: rtl/seq_multiplier_n.sv
// Iterative N-bit multiplier, unsigned or two's-complement, with a
// Start/Busy/Done handshake. Start accepted in IDLE or DONE; result
// appears N+2 cycles after acceptance.
module seq_multiplier_n
    import seq_multiplier_n_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    seq_multiplier_n_if.slave bus
);

    localparam int CW = cnt_width(N);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_mcand;
    logic            r_neg;
    logic            w_accept;
    logic [N-1:0]    w_a_mag;
    logic [N-1:0]    w_b_mag;
    logic            w_sign;
    logic [2*N-1:0]  w_p;

    assign w_accept = bus.i_start && (r_state == ST_IDLE || r_state == ST_DONE);

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(N-1) -- no extra bit needed.
    assign w_a_mag = (bus.i_signed_mode && bus.i_a[N-1]) ? -bus.i_a : bus.i_a;
    assign w_b_mag = (bus.i_signed_mode && bus.i_b[N-1]) ? -bus.i_b : bus.i_b;
    assign w_sign  = bus.i_signed_mode && (bus.i_a[N-1] ^ bus.i_b[N-1]);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.i_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == CW'(1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = bus.i_start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand/sign latches and bit counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_mcand <= w_a_mag;
            r_neg   <= w_sign;
            r_cnt   <= CW'(N);
        end else if (r_state == ST_RUN) begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    shift_add_datapath #(.N(N)) u_dp (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_accept),
        .i_step   (r_state == ST_RUN),
        .i_fix    (r_state == ST_FIX),
        .i_neg    (r_neg),
        .i_mcand  (r_mcand),
        .i_mplier (w_b_mag),
        .o_p      (w_p)
    );

    assign bus.o_busy = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign bus.o_done = (r_state == ST_DONE);
    assign bus.o_p    = w_p;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Scoreboard bench for seq_multiplier_n at N=4 and N=8.
module tb_seq_multiplier_n;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier_n_if #(.N(4)) if4 ();
    seq_multiplier_n_if #(.N(8)) if8 ();

    seq_multiplier_n #(.N(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(if4));
    seq_multiplier_n #(.N(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(if8));

    typedef struct {
        longint p;
        int     cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   total = 0;
    int   bad   = 0;
    bit   abort_win = 1'b0;
    logic [7:0]  prev_p4;
    logic [15:0] prev_p8;

    // Reference: plain integer multiply of the interpreted operands,
    // truncated to 2N bits.
    function automatic longint model(input int n, input longint a, input longint b, input bit s);
        longint ia, ib, half, full;
        half = longint'(1) << (n - 1);
        full = longint'(1) << n;
        ia = (s && a >= half) ? a - full : a;
        ib = (s && b >= half) ? b - full : b;
        return (ia * ib) & ((longint'(1) << (2 * n)) - 1);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one N=4 operation in the current cycle; returns in its DONE cycle.
    // noise: keep poking Start with junk operands while busy.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit s,
                       input bit noise, input bit push);
        if4.i_start = 1'b1; if4.i_a = a; if4.i_b = b; if4.i_signed_mode = s;
        if (push) q4.push_back('{model(4, a, b, s), cyc + 6});
        for (int k = 1; k <= 5; k++) begin
            tick();
            if4.i_start       = noise ? ((k == 2 || k == 3) ? 1'b1 : 1'($urandom)) : 1'b0;
            if4.i_a           = 4'($urandom);
            if4.i_b           = 4'($urandom);
            if4.i_signed_mode = 1'($urandom);
        end
        tick();
        if4.i_start = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s);
        if8.i_start = 1'b1; if8.i_a = a; if8.i_b = b; if8.i_signed_mode = s;
        q8.push_back('{model(8, a, b, s), cyc + 10});
        for (int k = 1; k <= 9; k++) begin
            tick();
            if8.i_start = 1'($urandom);
            if8.i_a     = 8'($urandom);
            if8.i_b     = 8'($urandom);
        end
        tick();
        if8.i_start = 1'b0;
    endtask

    // Monitor, N=4: Done pops the scoreboard; Busy follows the model timeline.
    always @(negedge clk) begin
        if (!rst) begin
            chk("excl4", if4.o_busy & if4.o_done, 0);
            if (!abort_win)
                chk("busy4", if4.o_busy,
                    (q4.size() > 0 && cyc >= q4[0].cyc - 5 && cyc <= q4[0].cyc - 1));
            if (if4.o_busy) chk("hold4", if4.o_p, prev_p4);
            if (if4.o_done) begin
                if (q4.size() == 0) chk("extra_done4", if4.o_done, 0);
                else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("p4", if4.o_p, e.p);
                    chk("lat4", cyc, e.cyc);
                end
            end
        end
        prev_p4 <= if4.o_p;
    end

    // Monitor, N=8.
    always @(negedge clk) begin
        if (!rst) begin
            chk("excl8", if8.o_busy & if8.o_done, 0);
            chk("busy8", if8.o_busy,
                (q8.size() > 0 && cyc >= q8[0].cyc - 9 && cyc <= q8[0].cyc - 1));
            if (if8.o_busy) chk("hold8", if8.o_p, prev_p8);
            if (if8.o_done) begin
                if (q8.size() == 0) chk("extra_done8", if8.o_done, 0);
                else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("p8", if8.o_p, e.p);
                    chk("lat8", cyc, e.cyc);
                end
            end
        end
        prev_p8 <= if8.o_p;
    end

    initial begin
        rst = 1'b1;
        if4.i_start = 1'b0; if4.i_a = '0; if4.i_b = '0; if4.i_signed_mode = 1'b0;
        if8.i_start = 1'b0; if8.i_a = '0; if8.i_b = '0; if8.i_signed_mode = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_p4", if4.o_p, 0);
        chk("rst_busy4", if4.o_busy, 0);
        chk("rst_done4", if4.o_done, 0);
        chk("rst_p8", if8.o_p, 0);

        // Directed N=4 corners.
        op4(4'hF, 4'hF, 1'b0, 1'b0, 1'b1); tick();
        op4(4'h8, 4'h8, 1'b1, 1'b0, 1'b1); tick();
        op4(4'hD, 4'h5, 1'b1, 1'b0, 1'b1); tick();
        op4(4'h0, 4'h9, 1'b1, 1'b0, 1'b1); tick();
        op4(4'h7, 4'h8, 1'b1, 1'b1, 1'b1); tick();   // Start while busy ignored

        // Random N=4 with random gaps (gap 0 = back-to-back).
        for (int i = 0; i < 40; i++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        // N=8 corners and randoms.
        op8(8'hFF, 8'hFF, 1'b0); tick();
        op8(8'h80, 8'h80, 1'b1); tick();
        for (int i = 0; i < 8; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 1)) tick();
        end
        tick();

        // Back-to-back, ending with P=0x0C, then abort a multiply in cycle 3.
        op4(4'd2, 4'd5, 1'b0, 1'b0, 1'b1);
        op4(4'd3, 4'd4, 1'b0, 1'b0, 1'b1);
        op4(4'd2, 4'd7, 1'b0, 1'b0, 1'b1);
        op4(4'd3, 4'd4, 1'b0, 1'b0, 1'b1);
        tick();
        abort_win = 1'b1;
        if4.i_start = 1'b1; if4.i_a = 4'd5; if4.i_b = 4'd5; if4.i_signed_mode = 1'b0;
        tick(); if4.i_start = 1'b0;
        tick();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("abort_p", if4.o_p, 0);
        chk("abort_busy", if4.o_busy, 0);
        chk("abort_done", if4.o_done, 0);
        abort_win = 1'b0;
        repeat (12) tick();

        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
